// File: rtl/array_feeder.sv
// array_feeder: accepts a 2x2 weight set and a stream of 2-row activation
// beats, and feeds them to a 2x2 systolic array. Weights are loaded with a
// one-cycle strobe. Activations are skewed so that row 1 lags row 0 by one
// cycle. After the last beat the block waits a fixed number of drain cycles,
// then pulses done.
module array_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [DATA_WIDTH-1:0] cfg_w00,
    input  logic [DATA_WIDTH-1:0] cfg_w01,
    input  logic [DATA_WIDTH-1:0] cfg_w10,
    input  logic [DATA_WIDTH-1:0] cfg_w11,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x0,
    input  logic [DATA_WIDTH-1:0] in_x1,
    input  logic                  in_last,
    output logic                  load_weights,
    output logic [DATA_WIDTH-1:0] w00,
    output logic [DATA_WIDTH-1:0] w01,
    output logic [DATA_WIDTH-1:0] w10,
    output logic [DATA_WIDTH-1:0] w11,
    output logic [DATA_WIDTH-1:0] x0,
    output logic [DATA_WIDTH-1:0] x1,
    output logic                  start,
    output logic                  done,
    output logic [7:0]            vec_count
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

    state_t                state_reg;
    logic [CW-1:0]         drain_cnt_reg;
    logic                  load_weights_reg;
    logic                  done_reg;
    logic                  start_reg;
    logic [DATA_WIDTH-1:0] x0_reg;
    logic [DATA_WIDTH-1:0] x1_reg;
    logic [DATA_WIDTH-1:0] x1_pend_reg;
    logic                  x1_pend_valid_reg;
    logic [7:0]            vec_count_reg;

    // Weight lanes are handled uniformly as a small array
    logic [DATA_WIDTH-1:0] cfg_w_arr [4];
    logic [DATA_WIDTH-1:0] w_reg     [4];

    logic cfg_xfer;
    logic in_xfer;
    logic drain_exit;
    logic next_is_drain;

    // Handshake readiness depends on state only
    assign cfg_ready = (state_reg == IDLE);
    assign in_ready  = (state_reg == STREAM);

    assign cfg_xfer      = cfg_valid && (state_reg == IDLE);
    assign in_xfer       = in_valid && (state_reg == STREAM);
    assign drain_exit    = (state_reg == DRAIN) && (drain_cnt_reg == DRAIN_LAST);
    assign next_is_drain = (in_xfer && in_last) || ((state_reg == DRAIN) && !drain_exit);

    assign cfg_w_arr[0] = cfg_w00;
    assign cfg_w_arr[1] = cfg_w01;
    assign cfg_w_arr[2] = cfg_w10;
    assign cfg_w_arr[3] = cfg_w11;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_weight
            // Each weight register captures only on an accepted weight set
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    w_reg[gi] <= '0;
                end else if (cfg_xfer) begin
                    w_reg[gi] <= cfg_w_arr[gi];
                end
            end
        end
    endgenerate

    // Job sequencing: state, drain counter and the load/done strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            drain_cnt_reg    <= '0;
            load_weights_reg <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            load_weights_reg <= cfg_xfer;
            done_reg         <= drain_exit;
            case (state_reg)
                IDLE: begin
                    if (cfg_xfer) begin
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    state_reg <= STREAM;
                end
                STREAM: begin
                    if (in_xfer && in_last) begin
                        state_reg     <= DRAIN;
                        drain_cnt_reg <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_exit) begin
                        state_reg <= IDLE;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Activation skew: row 0 goes out immediately, row 1 waits one cycle.
    // Empty slots carry zero so bubbles reach the array as zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_reg            <= '0;
            x1_reg            <= '0;
            x1_pend_reg       <= '0;
            x1_pend_valid_reg <= 1'b0;
            start_reg         <= 1'b0;
        end else begin
            x0_reg            <= in_xfer ? in_x0 : '0;
            x1_pend_reg       <= in_xfer ? in_x1 : '0;
            x1_pend_valid_reg <= in_xfer;
            x1_reg            <= x1_pend_reg;
            start_reg         <= in_xfer || x1_pend_valid_reg || next_is_drain;
        end
    end

    // Beat counter: cleared by a new weight set, saturates at 255
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_count_reg <= '0;
        end else if (cfg_xfer) begin
            vec_count_reg <= '0;
        end else if (in_xfer && (vec_count_reg != 8'hFF)) begin
            vec_count_reg <= vec_count_reg + 8'd1;
        end
    end

    assign load_weights = load_weights_reg;
    assign done         = done_reg;
    assign start        = start_reg;
    assign x0           = x0_reg;
    assign x1           = x1_reg;
    assign vec_count    = vec_count_reg;
    assign w00          = w_reg[0];
    assign w01          = w_reg[1];
    assign w10          = w_reg[2];
    assign w11          = w_reg[3];

endmodule

// File: tb/tb_array_feeder.sv
// Testbench for array_feeder: directed and randomized jobs checked against
// an event-based expectation built from beat acceptance times.
module tb_array_feeder;

    localparam int DW = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [DW-1:0] cfg_w00 = '0, cfg_w01 = '0, cfg_w10 = '0, cfg_w11 = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_x0 = '0, in_x1 = '0;
    logic          in_last = 1'b0;
    logic          load_weights;
    logic [DW-1:0] w00, w01, w10, w11;
    logic [DW-1:0] x0, x1;
    logic          start;
    logic          done;
    logic [7:0]    vec_count;

    int n_vec = 0;
    int n_err = 0;

    // Job plan: per-beat data and idle cycles inserted before each beat
    logic [7:0] plan_x0  [0:299];
    logic [7:0] plan_x1  [0:299];
    int         plan_gap [0:299];

    // Expected lane contents indexed by edge number within a job
    logic [7:0] ex0 [0:599];
    logic [7:0] ex1 [0:599];
    bit         ev0 [0:599];
    bit         ev1 [0:599];

    array_feeder #(.DATA_WIDTH(DW), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_w00(cfg_w00), .cfg_w01(cfg_w01), .cfg_w10(cfg_w10), .cfg_w11(cfg_w11),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x0(in_x0), .in_x1(in_x1), .in_last(in_last),
        .load_weights(load_weights),
        .w00(w00), .w01(w01), .w10(w10), .w11(w11),
        .x0(x0), .x1(x1), .start(start), .done(done), .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_weights(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
        chk("w00", {24'd0, w00}, {24'd0, a});
        chk("w01", {24'd0, w01}, {24'd0, b});
        chk("w10", {24'd0, w10}, {24'd0, c});
        chk("w11", {24'd0, w11}, {24'd0, d});
    endtask

    // Run one complete job following the plan; checks every cycle
    task automatic run_job(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d,
                           input int n, input bit cfg_noise);
        int  e, klast, bi, gapleft, accepted;
        bit  offer, exp_start;
        for (int i = 0; i < 600; i++) begin
            ex0[i] = '0; ex1[i] = '0; ev0[i] = 1'b0; ev1[i] = 1'b0;
        end
        // Weight offer in IDLE, with an activation offer that must be ignored
        cfg_valid = 1'b1;
        cfg_w00 = a; cfg_w01 = b; cfg_w10 = c; cfg_w11 = d;
        in_valid = 1'b1; in_x0 = 8'($urandom); in_x1 = 8'($urandom); in_last = 1'b1;
        @(posedge clk); #1;
        chk("load_strobe", {31'd0, load_weights}, 32'd1);
        chk_weights(a, b, c, d);
        chk("vec_clear", {24'd0, vec_count}, 32'd0);
        chk("cfg_ready_load", {31'd0, cfg_ready}, 32'd0);
        chk("in_ready_load", {31'd0, in_ready}, 32'd0);
        cfg_valid = cfg_noise;
        cfg_w00 = 8'($urandom); cfg_w01 = 8'($urandom);
        cfg_w10 = 8'($urandom); cfg_w11 = 8'($urandom);
        @(posedge clk); #1;
        chk("load_one_cycle", {31'd0, load_weights}, 32'd0);
        chk("in_ready_stream", {31'd0, in_ready}, 32'd1);
        chk("vec_after_load", {24'd0, vec_count}, 32'd0);

        e = 0; klast = -1; bi = 0; accepted = 0;
        gapleft = plan_gap[0];
        while (klast < 0 || e <= klast + D + 1) begin
            offer = (klast < 0) && (gapleft == 0);
            if (offer) begin
                in_valid = 1'b1;
                in_x0    = plan_x0[bi];
                in_x1    = plan_x1[bi];
                in_last  = (bi == n - 1);
            end else begin
                in_valid = (klast >= 0) ? 1'($urandom) : 1'b0;
                in_x0    = 8'($urandom);
                in_x1    = 8'($urandom);
                in_last  = 1'($urandom);
            end
            cfg_valid = cfg_noise && (klast < 0 || e <= klast + D);
            if (cfg_noise) begin
                cfg_w00 = 8'($urandom); cfg_w01 = 8'($urandom);
                cfg_w10 = 8'($urandom); cfg_w11 = 8'($urandom);
            end
            @(posedge clk); #1;
            if (offer) begin
                ev0[e] = 1'b1;     ex0[e] = plan_x0[bi];
                ev1[e + 1] = 1'b1; ex1[e + 1] = plan_x1[bi];
                accepted++;
                if (bi == n - 1) klast = e;
                bi++;
                if (bi < n) gapleft = plan_gap[bi];
            end else if (klast < 0) begin
                gapleft--;
            end
            exp_start = ev0[e] || ev1[e] || (klast >= 0 && e >= klast && e < klast + D);
            chk("x0", {24'd0, x0}, {24'd0, ex0[e]});
            chk("x1", {24'd0, x1}, {24'd0, ex1[e]});
            chk("start", {31'd0, start}, {31'd0, exp_start});
            chk("done", {31'd0, done}, {31'd0, (klast >= 0 && e == klast + D)});
            chk("in_ready", {31'd0, in_ready}, {31'd0, (klast < 0)});
            chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, (klast >= 0 && e >= klast + D)});
            chk("load_idle", {31'd0, load_weights}, 32'd0);
            chk("vec_count", {24'd0, vec_count}, (accepted > 255) ? 32'd255 : 32'(accepted));
            chk_weights(a, b, c, d);
            e++;
        end
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    initial begin
        int n;
        bit noise;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_vec", {24'd0, vec_count}, 32'd0);
        chk("rst_x", {16'd0, x0, x1}, 32'd0);
        chk("rst_strobes", {29'd0, load_weights, start, done}, 32'd0);
        chk_weights(8'd0, 8'd0, 8'd0, 8'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);

        // Weights 1..4, back-to-back beats (5,6),(7,8)
        plan_x0[0] = 8'd5; plan_x1[0] = 8'd6; plan_gap[0] = 0;
        plan_x0[1] = 8'd7; plan_x1[1] = 8'd8; plan_gap[1] = 0;
        run_job(8'd1, 8'd2, 8'd3, 8'd4, 2, 1'b0);

        // Same beats with a two-cycle bubble between them
        plan_gap[1] = 2;
        run_job(8'd1, 8'd2, 8'd3, 8'd4, 2, 1'b0);

        // Weight offers held high during the job must be ignored
        for (int i = 0; i < 3; i++) begin
            plan_x0[i] = 8'($urandom); plan_x1[i] = 8'($urandom); plan_gap[i] = i;
        end
        run_job(8'd9, 8'd10, 8'd11, 8'd12, 3, 1'b1);

        // Single-beat job
        plan_x0[0] = 8'hA5; plan_x1[0] = 8'h5A; plan_gap[0] = 1;
        run_job(8'h11, 8'h22, 8'h33, 8'h44, 1, 1'b0);

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            n = int'($urandom_range(1, 6));
            noise = 1'($urandom);
            for (int i = 0; i < n; i++) begin
                plan_x0[i] = 8'($urandom_range(1, 255));
                plan_x1[i] = 8'($urandom_range(1, 255));
                plan_gap[i] = int'($urandom_range(0, 2));
            end
            run_job(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), n, noise);
        end

        // Beat counter saturation
        for (int i = 0; i < 260; i++) begin
            plan_x0[i] = 8'($urandom); plan_x1[i] = 8'($urandom); plan_gap[i] = 0;
        end
        run_job(8'h5C, 8'hC5, 8'h01, 8'hFE, 260, 1'b0);

        // Reset in the middle of a stream after three beats
        cfg_valid = 1'b1;
        cfg_w00 = 8'd21; cfg_w01 = 8'd22; cfg_w10 = 8'd23; cfg_w11 = 8'd24;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_last = 1'b0;
            in_x0 = 8'($urandom_range(1, 255)); in_x1 = 8'($urandom_range(1, 255));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre_rst_vec", {24'd0, vec_count}, 32'd3);
        chk("pre_rst_start", {31'd0, start}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_x", {16'd0, x0, x1}, 32'd0);
        chk("midrst_strobes", {29'd0, load_weights, start, done}, 32'd0);
        chk("midrst_vec", {24'd0, vec_count}, 32'd0);
        chk("midrst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk_weights(8'd0, 8'd0, 8'd0, 8'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < D + 4; i++) begin
            @(posedge clk); #1;
            chk("abandon_done", {31'd0, done}, 32'd0);
            chk("abandon_start", {31'd0, start}, 32'd0);
            chk("abandon_cfg_ready", {31'd0, cfg_ready}, 32'd1);
            chk("abandon_vec", {24'd0, vec_count}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/array_feeder.md
ARRAY_FEEDER -- requirements
Module: array_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of weights and activations.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4, cycles held after last beat before done.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cfg_valid  input  1  weight-set offer.
REQ-006 cfg_ready  output  1  weight set acceptable (high in IDLE only).
REQ-007 cfg_w00, cfg_w01, cfg_w10, cfg_w11  input  DATA_WIDTH each  weight set.
REQ-008 in_valid  input  1  activation beat offer.
REQ-009 in_ready  output  1  beat acceptable (high in STREAM only).
REQ-010 in_x0, in_x1  input  DATA_WIDTH each  activation vector, rows 0 and 1.
REQ-011 in_last  input  1  marks final beat of a job.
REQ-012 load_weights  output  1  one-cycle weight-load strobe to the array.
REQ-013 w00, w01, w10, w11  output  DATA_WIDTH each  registered weights to the array.
REQ-014 x0, x1  output  DATA_WIDTH each  skewed activations to the array.
REQ-015 start  output  1  array valid/enable.
REQ-016 done  output  1  one-cycle job-complete pulse.
REQ-017 vec_count  output  8  beats accepted in current job.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, STREAM, DRAIN; reset state IDLE.
REQ-019 Transfer SHALL occur only when valid and ready are both high at a rising edge.
REQ-020 IDLE: on cfg transfer, capture cfg_w* into w*, clear vec_count, go to LOAD.
REQ-021 LOAD: load_weights high for exactly this one cycle; next state STREAM unconditionally.
REQ-022 STREAM: in_ready high; on transfer with in_last high, go to DRAIN; otherwise remain.
REQ-023 DRAIN: in_ready low; counter runs DRAIN_CYCLES cycles, then done high one cycle and return to IDLE.
REQ-024 Beat accepted at edge k: x0 = in_x0 from edge k; x1 = in_x1 from edge k+1 (one-cycle row skew).
REQ-025 Lane with no valid data SHALL drive 0 on its x output (bubbles when in_valid low).
REQ-026 start SHALL be high whenever either lane holds valid data or state is DRAIN; low otherwise.
REQ-027 vec_count SHALL increment per accepted beat, saturate at 255, hold after job until next cfg transfer.
REQ-028 w* SHALL hold value from last cfg transfer; no change outside IDLE transfer.
REQ-029 cfg_valid outside IDLE and in_valid outside STREAM SHALL be ignored, no state change.
REQ-030 Single-beat job (first beat has in_last) SHALL behave as REQ-022..024; x1 lane still emitted during DRAIN.
REQ-031 cfg_ready and in_ready SHALL be combinational decodes of state only, no dependency on valid inputs.

Reset
REQ-032 reset assertion SHALL immediately force state IDLE and zero all registers: w*, x0, x1, load_weights, start, done, vec_count, skew lanes, drain counter.
REQ-033 During and after reset, cfg_ready SHALL be 1 and in_ready 0.
REQ-034 reset mid-job (LOAD/STREAM/DRAIN) SHALL abandon job with no done pulse.

Verification
REQ-035 Load weights 1,2,3,4 -> load_weights high exactly one cycle after cfg transfer; w00..w11=1,2,3,4 held thereafter.
REQ-036 Stream beats (5,6),(7,8) back-to-back, last on second -> x0=5,7 on consecutive cycles; x1=6,8 one cycle later; zeros around; vec_count=2.
REQ-037 Beat (5,6), in_valid low 2 cycles, beat (7,8,last) -> x0 shows 5,0,0,7; start low only where no lane valid and not DRAIN.
REQ-038 Last beat accepted at edge k -> done high for exactly the cycle after DRAIN_CYCLES cycles of DRAIN (default 4), then cfg_ready=1.
REQ-039 cfg_valid held high during STREAM with new weights -> ignored; w* unchanged.
REQ-040 Assert reset during STREAM after 3 beats -> all outputs 0, vec_count=0, cfg_ready=1, no done pulse.
